uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
Controller between the UART receiver/transmitter and the ALU in the serial-ALU top level. It collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result one cycle later and hands it to the UART transmitter with a start/done handshake. An inter-byte timeout resynchronises the frame; bytes arriving while a result is in flight are flagged as overruns.

Parameters:
NB_DATA, 8, width of ALU operands, result and UART data bytes
NB_OPS, 6, width of ALU opcode (taken from opcode byte bits [NB_OPS-1:0])
TIMEOUT_CYCLES, 1000000, i_clk cycles allowed between bytes of one frame; 0 disables timeout
NB_TIMEOUT, 20, width of timeout counter (must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_data  in  NB_DATA  byte from UART receiver, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse: new received byte
i_alu_res  in  NB_DATA  combinational ALU result
i_tx_done  in  1  one-cycle pulse: transmitter finished the byte
o_data_a  out  NB_DATA  registered operand A to ALU
o_data_b  out  NB_DATA  registered operand B to ALU
o_ops  out  NB_OPS  registered opcode to ALU
o_tx_data  out  NB_DATA  registered result byte to transmitter
o_tx_start  out  1  one-cycle pulse: start transmission of o_tx_data
o_busy  out  1  high whenever state != WAIT_A
o_timeout  out  1  one-cycle pulse: frame aborted by timeout
o_overrun  out  1  one-cycle pulse: received byte dropped

Behaviour:
- One clock domain (i_clk). i_reset asynchronous, active-high. On reset: state=WAIT_A, all outputs 0, timeout counter 0. Reset mid-frame aborts silently (no o_timeout).
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a<=i_rx_data, go WAIT_B.
- WAIT_B: on i_rx_done, o_data_b<=i_rx_data, go WAIT_OP.
- WAIT_OP: on i_rx_done, o_ops<=i_rx_data[NB_OPS-1:0] (upper bits ignored), go EXEC.
- EXEC: one cycle for ALU settling. At the next edge o_tx_data<=i_alu_res, go SEND.
- SEND: o_tx_start=1 for exactly this one cycle (registered, asserted in the cycle after leaving EXEC), go WAIT_TX.
- WAIT_TX: wait for i_tx_done, then go WAIT_A.
- Latency: opcode byte sampled at edge E0 -> o_ops valid after E0 -> o_tx_data valid after E1 -> o_tx_start high between E1 and E2.
- Timeout: counter cleared on every accepted byte and in WAIT_A/EXEC/SEND/WAIT_TX. It increments each cycle in WAIT_B/WAIT_OP. When it reaches TIMEOUT_CYCLES with no i_rx_done: go WAIT_A, pulse o_timeout, counter cleared. o_data_a/o_data_b/o_ops keep their values.
- i_rx_done on the same edge as expiry: the byte is accepted and there is no timeout.
- i_rx_done in EXEC or SEND: byte dropped, o_overrun pulses.
- i_rx_done in WAIT_TX with i_tx_done=0: byte dropped, o_overrun pulses.
- i_rx_done and i_tx_done on the same edge in WAIT_TX: the byte is accepted as operand A and state goes to WAIT_B. No overrun.
- i_tx_done outside WAIT_TX: ignored.
- o_ops/o_data_* are held stable from capture until the next capture, so the ALU input is stable through EXEC.
- Pulses o_timeout/o_overrun are registered, high for one cycle, cycle after the causing edge.

Decomposition:
- Shared package uart_alu_pkg: state encoding localparams (3-bit), NB_DATA/NB_OPS defaults, ALU opcode constants (OP_ADD=6'b100000, OP_SUB=6'b100010, OP_AND=6'b100100, OP_OR=6'b100101, OP_XOR=6'b100110, OP_SRA=6'b000011, OP_SRL=6'b000010, OP_NOR=6'b100111) for benches.
- One sub-module: frame_timeout_counter (clear, enable, expire pulse, parameterised by TIMEOUT_CYCLES/NB_TIMEOUT).
- FSM and capture registers stay in the top sequencer.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with the ALU model computing A+B -> o_data_a=0x05, o_data_b=0x03, o_ops=0x20. o_tx_data=0x08 with o_tx_start high exactly one cycle, between edges E1 and E2 after the opcode byte. i_tx_done -> o_busy=0.
- TIMEOUT_CYCLES=16: byte 0x7F, then silence -> o_timeout pulse 16 cycles after acceptance, state WAIT_A, o_data_a still 0x7F. Next bytes 0xFE,0x02,0x22 -> o_tx_data=0xFC (SUB).
- TIMEOUT_CYCLES=16: byte arrives exactly on expiry edge -> accepted as operand B, no o_timeout.
- Byte 0x55 during WAIT_TX -> o_overrun one cycle, no register change. Then the same byte coincident with i_tx_done -> o_data_a=0x55, state WAIT_B, no overrun.
- Reset asserted asynchronously (mid-cycle) in WAIT_OP -> all outputs 0 immediately, no o_timeout. The following full frame (0x0F,0xF0,0x25 OR) -> o_tx_data=0xFF.
- Opcode byte 0xE0 -> o_ops=6'b100000 (upper bits stripped), result sent normally.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the serial-ALU top level: sequencer state
// encoding, default data widths and the ALU opcode map used by benches.
package uart_alu_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OPS_DEF  = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout counter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count (has priority over enable)
//   enable    - count this cycle
//   expire    - combinational: the current enabled cycle is the
//               TIMEOUT_CYCLES-th since the last clear
// TIMEOUT_CYCLES = 0 disables expiry.
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(LAST_I);

    logic [NB_TIMEOUT-1:0] count;

    // count holds the number of elapsed enabled cycles; the edge that would
    // make it reach TIMEOUT_CYCLES is the expiry edge.
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Sequencer between UART rx/tx and the ALU: collects A, B and opcode
// bytes, presents them to the ALU, captures the result one cycle later
// and hands it to the transmitter.
// Ports:
//   i_clk, i_reset        - clock, asynchronous active-high reset
//   i_rx_data, i_rx_done  - received byte and its one-cycle strobe
//   i_alu_res             - combinational ALU result
//   i_tx_done             - transmitter finished strobe
//   o_data_a/o_data_b/o_ops - registered ALU operands and opcode
//   o_tx_data, o_tx_start - result byte and one-cycle start pulse
//   o_busy                - frame in progress (state != WAIT_A)
//   o_timeout, o_overrun  - one-cycle event pulses
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DEF,
    parameter int unsigned NB_OPS         = NB_OPS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_res,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OPS-1:0]  o_ops,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t state, state_nxt;

    logic [NB_DATA-1:0] data_a_nxt, data_b_nxt, tx_data_nxt;
    logic [NB_OPS-1:0]  ops_nxt;
    logic               tx_start_nxt, timeout_nxt, overrun_nxt;
    logic               collecting, expire;

    assign collecting = (state == WAIT_B) || (state == WAIT_OP);

    // An accepted byte clears the count, so a byte on the expiry edge wins.
    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMEOUT     (NB_TIMEOUT)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_reset),
        .clear  (!collecting || i_rx_done),
        .enable (collecting),
        .expire (expire)
    );

    always_comb begin
        state_nxt    = state;
        data_a_nxt   = o_data_a;
        data_b_nxt   = o_data_b;
        ops_nxt      = o_ops;
        tx_data_nxt  = o_tx_data;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        overrun_nxt  = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_nxt = i_rx_data;
                    state_nxt  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    data_b_nxt = i_rx_data;
                    state_nxt  = WAIT_OP;
                end else if (expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    ops_nxt   = i_rx_data[NB_OPS-1:0];
                    state_nxt = EXEC;
                end else if (expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_nxt  = i_alu_res;
                tx_start_nxt = 1'b1;
                overrun_nxt  = i_rx_done;
                state_nxt    = SEND;
            end
            SEND: begin
                overrun_nxt = i_rx_done;
                state_nxt   = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    // A byte coincident with tx completion starts the next frame.
                    if (i_rx_done) begin
                        data_a_nxt = i_rx_data;
                        state_nxt  = WAIT_B;
                    end else begin
                        state_nxt  = WAIT_A;
                    end
                end else begin
                    overrun_nxt = i_rx_done;
                end
            end
            default: state_nxt = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_ops      <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_data_a   <= data_a_nxt;
            o_data_b   <= data_b_nxt;
            o_ops      <= ops_nxt;
            o_tx_data  <= tx_data_nxt;
            o_tx_start <= tx_start_nxt;
            o_timeout  <= timeout_nxt;
            o_overrun  <= overrun_nxt;
        end
    end

    assign o_busy = (state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: directed scenarios plus random traffic,
// all outputs compared each cycle against a frame-level reference model.
module tb_uart_alu_sequencer;
    import uart_alu_pkg::*;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic [7:0] alu_res;
    logic       tx_done = 1'b0;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] ops;
    logic       tx_start, busy, timeout, overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_DATA        (8),
        .NB_OPS         (6),
        .TIMEOUT_CYCLES (TO),
        .NB_TIMEOUT     (5)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_alu_res  (alu_res),
        .i_tx_done  (tx_done),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_ops      (ops),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_timeout  (timeout),
        .o_overrun  (overrun)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return 8'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    // The ALU sits outside the sequencer, fed by its operand registers.
    assign alu_res = alu_fn(data_a, data_b, ops);

    // Reference model: bytes gathered so far in the frame, and the stage of
    // the result hand-off (0 none, 1 settling, 2 starting, 3 awaiting tx).
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_ops;
    logic       m_start, m_to, m_ov;
    int         got, post, silence;

    task automatic model_reset();
        m_a = '0; m_b = '0; m_ops = '0; m_tx = '0;
        m_start = 0; m_to = 0; m_ov = 0;
        got = 0; post = 0; silence = 0;
    endtask

    task automatic take_byte(input logic [7:0] d);
        silence = 0;
        if (got == 0) begin
            m_a = d; got = 1;
        end else if (got == 1) begin
            m_b = d; got = 2;
        end else begin
            m_ops = d[5:0]; got = 0; post = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            m_start = 0; m_to = 0; m_ov = 0;
            if (post == 1) begin
                m_tx = alu_fn(m_a, m_b, m_ops);
                m_start = 1; post = 2; m_ov = rx_done;
            end else if (post == 2) begin
                post = 3; m_ov = rx_done;
            end else if (post == 3) begin
                if (tx_done) begin
                    post = 0;
                    if (rx_done) take_byte(rx_data);
                end else begin
                    m_ov = rx_done;
                end
            end else if (rx_done) begin
                take_byte(rx_data);
            end else if (got > 0) begin
                silence++;
                if (silence == TO) begin
                    got = 0; silence = 0; m_to = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    task automatic check_all();
        chk("data_a",   32'(data_a),   32'(m_a));
        chk("data_b",   32'(data_b),   32'(m_b));
        chk("ops",      32'(ops),      32'(m_ops));
        chk("tx_data",  32'(tx_data),  32'(m_tx));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("busy",     32'(busy),     32'((got > 0) || (post > 0)));
        chk("timeout",  32'(timeout),  32'(m_to));
        chk("overrun",  32'(overrun),  32'(m_ov));
    endtask

    // Drive inputs for one edge, then compare at the following falling edge.
    task automatic tick(input logic rxv, input logic [7:0] rxd, input logic txd);
        rx_done = rxv; rx_data = rxd; tx_done = txd;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        tick(1'b1, a, 1'b0);
        tick(1'b1, b, 1'b0);
        tick(1'b1, op, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Basic ADD frame with exact start-pulse timing.
        frame(8'h05, 8'h03, 8'h20);
        chk("e0_ops", 32'(ops), 32'h20);
        chk("e0_start", 32'(tx_start), 32'd0);
        idle(1);
        chk("e1_tx", 32'(tx_data), 32'h08);
        chk("e1_start", 32'(tx_start), 32'd1);
        idle(1);
        chk("e2_start", 32'(tx_start), 32'd0);
        chk("e2_busy", 32'(busy), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        chk("txd_busy", 32'(busy), 32'd0);

        // Timeout after operand A.
        tick(1'b1, 8'h7F, 1'b0);
        idle(TO - 1);
        chk("pre_to", 32'(timeout), 32'd0);
        idle(1);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_a", 32'(data_a), 32'h7F);
        idle(1);
        chk("to_once", 32'(timeout), 32'd0);
        frame(8'hFE, 8'h02, 8'h22);
        idle(1);
        chk("sub_tx", 32'(tx_data), 32'hFC);
        idle(1);
        tick(1'b0, 8'h00, 1'b1);

        // Byte on the expiry edge is accepted.
        tick(1'b1, 8'h10, 1'b0);
        idle(TO - 1);
        tick(1'b1, 8'h20, 1'b0);
        chk("exp_b", 32'(data_b), 32'h20);
        chk("exp_no_to", 32'(timeout), 32'd0);
        tick(1'b1, 8'h20, 1'b0);
        idle(2);
        chk("exp_tx", 32'(tx_data), 32'h30);
        tick(1'b0, 8'h00, 1'b1);

        // Overrun in WAIT_TX, then a byte coincident with tx_done.
        frame(8'h11, 8'h22, 8'h20);
        idle(2);
        tick(1'b1, 8'h55, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_a", 32'(data_a), 32'h11);
        tick(1'b1, 8'h55, 1'b1);
        chk("coinc_a", 32'(data_a), 32'h55);
        chk("coinc_ovr", 32'(overrun), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd1);
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h20, 1'b0);
        idle(2);
        chk("coinc_tx", 32'(tx_data), 32'h56);
        tick(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in WAIT_OP.
        tick(1'b1, 8'h33, 1'b0);
        tick(1'b1, 8'h44, 1'b0);
        rx_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_a", 32'(data_a), 32'd0);
        chk("arst_b", 32'(data_b), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(TO + 2);
        frame(8'h0F, 8'hF0, 8'h25);
        idle(1);
        chk("or_tx", 32'(tx_data), 32'hFF);
        idle(1);
        tick(1'b0, 8'h00, 1'b1);

        // Upper opcode bits are stripped.
        frame(8'h03, 8'h04, 8'hE0);
        chk("strip_ops", 32'(ops), 32'h20);
        idle(1);
        chk("strip_tx", 32'(tx_data), 32'h07);
        idle(1);
        tick(1'b0, 8'h00, 1'b1);

        // Random traffic with occasional silent gaps.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 7))
                    0: d[5:0] = OP_ADD;
                    1: d[5:0] = OP_SUB;
                    2: d[5:0] = OP_AND;
                    3: d[5:0] = OP_OR;
                    4: d[5:0] = OP_XOR;
                    5: d[5:0] = OP_SRA;
                    6: d[5:0] = OP_SRL;
                    default: d[5:0] = OP_NOR;
                endcase
            end
            if ($urandom_range(0, 40) == 0) idle(int'($urandom_range(TO - 2, TO + 2)));
            tick(1'($urandom_range(0, 3) == 0), d, 1'($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
